// File: rtl/bayer_frame_ctrl_if.sv
// -----------------------------------------------------------------------------
// bayer_frame_ctrl_if
//   Pixel stream bundle for the Bayer frame controller.
//   Input side : s_data / s_valid / s_ready  (raw sensor stream, valid/ready)
//   Output side: raw_data / raw_valid / raw_sop / raw_eop (framed stream to ISP)
//   Modports:
//     master - pixel source / downstream observer (drives s_data, s_valid)
//     slave  - the frame controller (drives s_ready and the raw_* outputs)
// -----------------------------------------------------------------------------
interface bayer_frame_ctrl_if #(
   parameter int DATA_WIDTH = 16
);
   logic [DATA_WIDTH-1:0] s_data;
   logic                  s_valid;
   logic                  s_ready;
   logic [DATA_WIDTH-1:0] raw_data;
   logic                  raw_valid;
   logic                  raw_sop;
   logic                  raw_eop;

   modport master (
      output s_data,
      output s_valid,
      input  s_ready,
      input  raw_data,
      input  raw_valid,
      input  raw_sop,
      input  raw_eop
   );

   modport slave (
      input  s_data,
      input  s_valid,
      output s_ready,
      output raw_data,
      output raw_valid,
      output raw_sop,
      output raw_eop
   );
endinterface

// File: rtl/bayer_frame_ctrl.sv
// -----------------------------------------------------------------------------
// bayer_frame_ctrl
//   Frame sequencer and configuration controller in front of the Bayer stage.
//   Frames a raw valid/ready pixel stream into lines of the configured width,
//   applies staged Bayer configuration atomically at frame start and reports
//   frame completion / errors.
//
//   Optional feature macro: BAYER_FRAME_CTRL_TIMEOUT_EN
//     defined   - ACTIVE watchdog; after TIMEOUT_CYCLES handshake-free cycles
//                 err_o[1] is set and the frame is abandoned (no done pulse).
//     undefined - no watchdog, err_o[1] is constant 0.
//
//   Ports
//     clk_i, rst_n_i   clock, asynchronous active-low reset
//     cfg_wr_i         register write strobe
//     cfg_addr_i       0:width 1:height 2:{en[3:0],offset[7:0]} 3:{cont,stop,start}
//     cfg_wdata_i      register write data
//     pix              stream bundle (slave): s_* input, raw_* framed output
//     act_offset_o     black level of the running frame
//     act_en_o         {wb,lsc,dpc,blc} enables of the running frame
//     busy_o           controller not idle
//     frame_done_o     one-cycle pulse at frame end
//     err_o            sticky {timeout, cfg_err}
//     err_clr_i        clears err_o (a simultaneous new error wins)
// -----------------------------------------------------------------------------
module bayer_frame_ctrl #(
   parameter int DATA_WIDTH     = 16,
   parameter int DIM_W          = 13,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic               clk_i,
   input  logic               rst_n_i,
   input  logic               cfg_wr_i,
   input  logic [1:0]         cfg_addr_i,
   input  logic [31:0]        cfg_wdata_i,
   bayer_frame_ctrl_if.slave  pix,
   output logic [7:0]         act_offset_o,
   output logic [3:0]         act_en_o,
   output logic               busy_o,
   output logic               frame_done_o,
   output logic [1:0]         err_o,
   input  logic               err_clr_i
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_LOAD   = 2'd1;
   localparam logic [1:0] ST_ACTIVE = 2'd2;
   localparam logic [1:0] ST_DONE   = 2'd3;

   logic [1:0]            state_reg, state_next;

   // staging (software-visible) registers
   logic [DIM_W-1:0]      width_stg_reg, height_stg_reg;
   logic [7:0]            offset_stg_reg;
   logic [3:0]            en_stg_reg;
   logic                  cont_reg, start_req_reg, stop_pend_reg;

   // shadow registers owned by the running frame
   logic [DIM_W-1:0]      width_act_reg, height_act_reg;
   logic [7:0]            offset_act_reg;
   logic [3:0]            en_act_reg;
   logic [DIM_W-1:0]      x_reg, y_reg;

   logic [DATA_WIDTH-1:0] raw_data_reg;
   logic                  raw_valid_reg, raw_sop_reg, raw_eop_reg;
   logic                  frame_done_reg;
   logic [1:0]            err_reg, err_set, err_next;

   logic                  wr_width, wr_height, wr_bayer, wr_ctrl;
   logic                  ctrl_start, ctrl_stop;
   logic                  cfg_ok, hs, last_x, last_y;
   logic                  cfg_err_set, to_expire, stop_clr;
   logic                  unused_wdata;

   assign wr_width   = cfg_wr_i && (cfg_addr_i == 2'd0);
   assign wr_height  = cfg_wr_i && (cfg_addr_i == 2'd1);
   assign wr_bayer   = cfg_wr_i && (cfg_addr_i == 2'd2);
   assign wr_ctrl    = cfg_wr_i && (cfg_addr_i == 2'd3);
   // stop and start in one write: stop wins, the start is dropped
   assign ctrl_start = wr_ctrl && cfg_wdata_i[0] && !cfg_wdata_i[1];
   assign ctrl_stop  = wr_ctrl && cfg_wdata_i[1];
   assign unused_wdata = ^cfg_wdata_i;

   assign cfg_ok = (width_stg_reg >= DIM_W'(2)) && (height_stg_reg != '0);
   assign hs     = (state_reg == ST_ACTIVE) && pix.s_valid;
   assign last_x = (x_reg == width_act_reg - DIM_W'(1));
   assign last_y = (y_reg == height_act_reg - DIM_W'(1));

`ifdef BAYER_FRAME_CTRL_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TO_W-1:0] to_cnt_reg;

   // counts handshake-free ACTIVE cycles; expiry fires on the cycle that
   // would bring the count to TIMEOUT_CYCLES
   assign to_expire = (state_reg == ST_ACTIVE) && !hs &&
                      (to_cnt_reg == TO_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         to_cnt_reg <= '0;
      end else if ((state_reg != ST_ACTIVE) || hs) begin
         to_cnt_reg <= '0;
      end else begin
         to_cnt_reg <= to_cnt_reg + TO_W'(1);
      end
   end
`else
   assign to_expire = 1'b0;
`endif

   always_comb begin
      state_next  = state_reg;
      cfg_err_set = 1'b0;
      stop_clr    = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (start_req_reg) begin
               if (cfg_ok) state_next = ST_LOAD;
               else        cfg_err_set = 1'b1;
            end
         end
         ST_LOAD: state_next = ST_ACTIVE;
         ST_ACTIVE: begin
            if (hs && last_x && last_y) begin
               state_next = ST_DONE;
            end else if (to_expire) begin
               state_next = ST_IDLE;
               stop_clr   = 1'b1;
            end
         end
         ST_DONE: begin
            if (cont_reg && !stop_pend_reg) begin
               state_next = ST_LOAD;
            end else begin
               state_next = ST_IDLE;
               stop_clr   = 1'b1;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // sticky error bits: a new error in the clear cycle survives the clear
   assign err_set = {to_expire, cfg_err_set};
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_err
         assign err_next[gi] = err_set[gi] | (err_reg[gi] & ~err_clr_i);
      end
   endgenerate

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_reg      <= ST_IDLE;
         width_stg_reg  <= '0;
         height_stg_reg <= '0;
         offset_stg_reg <= '0;
         en_stg_reg     <= '0;
         cont_reg       <= 1'b0;
         start_req_reg  <= 1'b0;
         stop_pend_reg  <= 1'b0;
         width_act_reg  <= '0;
         height_act_reg <= '0;
         offset_act_reg <= '0;
         en_act_reg     <= '0;
         x_reg          <= '0;
         y_reg          <= '0;
         raw_data_reg   <= '0;
         raw_valid_reg  <= 1'b0;
         raw_sop_reg    <= 1'b0;
         raw_eop_reg    <= 1'b0;
         frame_done_reg <= 1'b0;
         err_reg        <= '0;
      end else begin
         state_reg <= state_next;

         if (wr_width)  width_stg_reg  <= cfg_wdata_i[DIM_W-1:0];
         if (wr_height) height_stg_reg <= cfg_wdata_i[DIM_W-1:0];
         if (wr_bayer) begin
            offset_stg_reg <= cfg_wdata_i[7:0];
            en_stg_reg     <= cfg_wdata_i[11:8];
         end
         if (wr_ctrl) cont_reg <= cfg_wdata_i[2];

         // IDLE consumes a pending start every cycle (LOAD or error), and
         // any start arriving while busy is dropped
         start_req_reg <= (state_reg == ST_IDLE) ? ctrl_start : 1'b0;

         if (ctrl_stop)     stop_pend_reg <= 1'b1;
         else if (stop_clr) stop_pend_reg <= 1'b0;

         if (state_reg == ST_LOAD) begin
            width_act_reg  <= width_stg_reg;
            height_act_reg <= height_stg_reg;
            offset_act_reg <= offset_stg_reg;
            en_act_reg     <= en_stg_reg;
            x_reg          <= '0;
            y_reg          <= '0;
         end else if (hs) begin
            if (last_x) begin
               x_reg <= '0;
               y_reg <= y_reg + DIM_W'(1);
            end else begin
               x_reg <= x_reg + DIM_W'(1);
            end
         end

         raw_valid_reg <= hs;
         raw_sop_reg   <= hs && (x_reg == '0) && (y_reg == '0);
         raw_eop_reg   <= hs && last_x;
         if (hs) raw_data_reg <= pix.s_data;

         frame_done_reg <= (state_reg == ST_ACTIVE) && (state_next == ST_DONE);
         err_reg        <= err_next;
      end
   end

   assign pix.s_ready   = (state_reg == ST_ACTIVE);
   assign pix.raw_data  = raw_data_reg;
   assign pix.raw_valid = raw_valid_reg;
   assign pix.raw_sop   = raw_sop_reg;
   assign pix.raw_eop   = raw_eop_reg;
   assign act_offset_o  = offset_act_reg;
   assign act_en_o      = en_act_reg;
   assign busy_o        = (state_reg != ST_IDLE);
   assign frame_done_o  = frame_done_reg;
   assign err_o         = err_reg;

endmodule

// File: tb/tb_bayer_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bayer_frame_ctrl
//   Directed bench for bayer_frame_ctrl: framing, continuous mode with stop,
//   atomic configuration apply, configuration errors, stop+start precedence,
//   mid-frame reset and (with BAYER_FRAME_CTRL_TIMEOUT_EN) the watchdog.
// -----------------------------------------------------------------------------
module tb_bayer_frame_ctrl;
   localparam int DW = 16;
`ifdef BAYER_FRAME_CTRL_TIMEOUT_EN
   localparam int TO_CYC = 16;
`else
   localparam int TO_CYC = 65535;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cfg_wr = 1'b0;
   logic [1:0]  cfg_addr = '0;
   logic [31:0] cfg_wdata = '0;
   logic        err_clr = 1'b0;
   logic [7:0]  act_offset;
   logic [3:0]  act_en;
   logic        busy, frame_done;
   logic [1:0]  err;

   bayer_frame_ctrl_if #(.DATA_WIDTH(DW)) pix ();

   bayer_frame_ctrl #(
      .DATA_WIDTH     (DW),
      .DIM_W          (13),
      .TIMEOUT_CYCLES (TO_CYC)
   ) dut (
      .clk_i        (clk),
      .rst_n_i      (rst_n),
      .cfg_wr_i     (cfg_wr),
      .cfg_addr_i   (cfg_addr),
      .cfg_wdata_i  (cfg_wdata),
      .pix          (pix),
      .act_offset_o (act_offset),
      .act_en_o     (act_en),
      .busy_o       (busy),
      .frame_done_o (frame_done),
      .err_o        (err),
      .err_clr_i    (err_clr)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_mis = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, got);
      end
   endtask

   // output monitor: one line per framed pixel
   int          mon_n = 0;
   int          done_n = 0;
   logic [15:0] done_pix = '0;
   logic [15:0] mon_data [0:255];
   logic        mon_sop  [0:255];
   logic        mon_eop  [0:255];

   always @(negedge clk) begin
      if (pix.raw_valid && mon_n < 256) begin
         mon_data[mon_n] <= pix.raw_data;
         mon_sop[mon_n]  <= pix.raw_sop;
         mon_eop[mon_n]  <= pix.raw_eop;
         mon_n           <= mon_n + 1;
         $display("pix  data=0x%04h sop=%0b eop=%0b", pix.raw_data, pix.raw_sop, pix.raw_eop);
      end
      if (frame_done) begin
         done_n   <= done_n + 1;
         done_pix <= pix.raw_valid ? pix.raw_data : 16'hFFFF;
         $display("done frame");
      end
   end

   int gap_q[$];

   task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
      cfg_addr  = a;
      cfg_wdata = d;
      cfg_wr    = 1'b1;
      @(negedge clk);
      cfg_wr    = 1'b0;
   endtask

   // stream n pixels (bounded by max_cyc); records s_ready-low gaps between
   // ready runs into gap_q
   task automatic send_pixels(input int n, input int max_cyc, input logic [15:0] first,
                              output int sent);
      int cyc = 0;
      bit hs;
      bit seen_hi = 0;
      int low = 0;
      sent        = 0;
      pix.s_data  = first;
      pix.s_valid = 1'b1;
      while (sent < n && cyc < max_cyc) begin
         hs = pix.s_ready;
         if (pix.s_ready) begin
            if (seen_hi && low > 0) gap_q.push_back(low);
            seen_hi = 1;
            low     = 0;
         end else begin
            low++;
         end
         @(negedge clk);
         cyc++;
         if (hs) begin
            sent++;
            pix.s_data = pix.s_data + 16'd1;
         end
      end
      pix.s_valid = 1'b0;
   endtask

   initial begin
      int sent, base, dn0;
      logic [7:0] sop_v, eop_v;
      pix.s_data  = '0;
      pix.s_valid = 1'b0;

      // reset state
      repeat (2) @(negedge clk);
      check_val("rst_busy", busy, 0);
      check_val("rst_ready", pix.s_ready, 0);
      check_val("rst_raw_valid", pix.raw_valid, 0);
      check_val("rst_err", err, 0);
      check_val("rst_offset", act_offset, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // 1: 4x2 frame, data 0..7
      cfg_write(2'd0, 32'd4);
      cfg_write(2'd1, 32'd2);
      cfg_write(2'd2, 32'h510);
      base = mon_n; dn0 = done_n;
      cfg_write(2'd3, 32'h1);
      send_pixels(8, 40, 16'd0, sent);
      repeat (2) @(negedge clk);
      check_val("t1_sent", sent, 8);
      check_val("t1_nout", mon_n - base, 8);
      for (int i = 0; i < 8; i++) begin
         check_val($sformatf("t1_data%0d", i), mon_data[base + i], i);
         sop_v[i] = mon_sop[base + i];
         eop_v[i] = mon_eop[base + i];
      end
      check_val("t1_sop", sop_v, 8'b0000_0001);
      check_val("t1_eop", eop_v, 8'b1000_1000);
      check_val("t1_done_cnt", done_n - dn0, 1);
      check_val("t1_done_pix", done_pix, 16'd7);
      check_val("t1_offset", act_offset, 8'h10);
      check_val("t1_en", act_en, 4'h5);
      check_val("t1_idle", busy, 0);

      // 2: continuous 2x1 frames, stop mid-frame
      cfg_write(2'd0, 32'd2);
      cfg_write(2'd1, 32'd1);
      gap_q.delete();
      base = mon_n; dn0 = done_n;
      cfg_write(2'd3, 32'h5);
      fork
         send_pixels(10, 20, 16'h100, sent);
         begin
            repeat (6) @(negedge clk);
            cfg_write(2'd3, 32'h6);
         end
      join
      repeat (2) @(negedge clk);
      check_val("t2_sent", sent, 4);
      check_val("t2_ngaps", gap_q.size(), 1);
      if (gap_q.size() > 0) check_val("t2_gap", gap_q[0], 2);
      check_val("t2_done_cnt", done_n - dn0, 2);
      check_val("t2_idle", busy, 0);
      for (int i = 0; i < 4; i++) begin
         check_val($sformatf("t2_data%0d", i), mon_data[base + i], 16'h100 + i);
         sop_v[i] = mon_sop[base + i];
         eop_v[i] = mon_eop[base + i];
      end
      check_val("t2_sop", sop_v[3:0], 4'b0101);
      check_val("t2_eop", eop_v[3:0], 4'b1010);

      // 3: staging write during ACTIVE is deferred to the next LOAD
      cfg_write(2'd3, 32'h0);
      cfg_write(2'd0, 32'd4);
      cfg_write(2'd1, 32'd2);
      cfg_write(2'd3, 32'h1);
      fork
         send_pixels(8, 40, 16'h200, sent);
         begin
            repeat (4) @(negedge clk);
            cfg_write(2'd2, 32'h320);
            check_val("t3_mid_busy", busy, 1);
            check_val("t3_mid_offset", act_offset, 8'h10);
            check_val("t3_mid_en", act_en, 4'h5);
         end
      join
      repeat (2) @(negedge clk);
      check_val("t3_sent", sent, 8);
      check_val("t3_after_offset", act_offset, 8'h10);
      cfg_write(2'd3, 32'h1);
      repeat (2) @(negedge clk);
      check_val("t3_load_offset", act_offset, 8'h20);
      check_val("t3_load_en", act_en, 4'h3);
      send_pixels(8, 40, 16'h0, sent);
      repeat (2) @(negedge clk);
      check_val("t3_sent2", sent, 8);

      // 4: configuration errors
      cfg_write(2'd0, 32'd1);
      cfg_write(2'd3, 32'h1);
      repeat (3) @(negedge clk);
      check_val("t4_w1_busy", busy, 0);
      check_val("t4_w1_err", err, 2'b01);
      repeat (2) @(negedge clk);
      check_val("t4_sticky", err, 2'b01);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      check_val("t4_clr", err, 2'b00);
      cfg_write(2'd0, 32'd2);
      cfg_write(2'd1, 32'd0);
      cfg_write(2'd3, 32'h1);
      err_clr = 1'b1;                 // same cycle as the h=0 error
      @(negedge clk);
      err_clr = 1'b0;
      check_val("t4_set_wins", err, 2'b01);
      check_val("t4_h0_busy", busy, 0);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      check_val("t4_clr2", err, 2'b00);

      // 5: stop+start together -> no start
      cfg_write(2'd0, 32'd4);
      cfg_write(2'd1, 32'd2);
      cfg_write(2'd3, 32'h3);
      repeat (3) @(negedge clk);
      check_val("t5_busy", busy, 0);
      check_val("t5_ready", pix.s_ready, 0);
      check_val("t5_err", err, 0);

      // mid-frame reset
      cfg_write(2'd3, 32'h1);
      send_pixels(3, 20, 16'h300, sent);
      check_val("rst_mid_sent", sent, 3);
      check_val("rst_mid_pre_valid", pix.raw_valid, 1);
      dn0 = done_n;
      rst_n = 1'b0;
      #1;
      check_val("rst_mid_busy", busy, 0);
      check_val("rst_mid_valid", pix.raw_valid, 0);
      check_val("rst_mid_data", pix.raw_data, 0);
      check_val("rst_mid_eop", pix.raw_eop, 0);
      check_val("rst_mid_offset", act_offset, 0);
      check_val("rst_mid_en", act_en, 0);
      check_val("rst_mid_ready", pix.s_ready, 0);
      repeat (3) @(negedge clk);
      check_val("rst_mid_no_done", done_n - dn0, 0);
      rst_n = 1'b1;
      @(negedge clk);

`ifdef BAYER_FRAME_CTRL_TIMEOUT_EN
      // 6: watchdog, TIMEOUT_CYCLES=16
      cfg_write(2'd0, 32'd4);
      cfg_write(2'd1, 32'd2);
      dn0 = done_n;
      cfg_write(2'd3, 32'h1);
      repeat (2) @(negedge clk);
      check_val("t6_active", pix.s_ready, 1);
      repeat (15) @(negedge clk);
      check_val("t6_still_busy", busy, 1);
      @(negedge clk);
      check_val("t6_busy", busy, 0);
      check_val("t6_err", err, 2'b10);
      check_val("t6_no_done", done_n - dn0, 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
